// File: rtl/fp_postcomp_pipe_if.sv
// Handshake/data bundle for fp_postcomp_pipe.
// master: upstream/downstream environment (drives beat inputs, out_ready, flush).
// slave : the post-complement pipeline (drives in_ready and the corrected beat).
//   flush      synchronous drop of all in-flight beats
//   in_valid / in_ready      input handshake
//   complement, co_i, sign_i, operand   raw adder result
//   out_valid / out_ready    output handshake
//   mag_o, co_o, sign_o, zero_o, lzc_o  corrected result and normaliser hints
interface fp_postcomp_pipe_if #(
  parameter int unsigned W   = 27,
  parameter int unsigned LZW = $clog2(W + 1)
) ();
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic           complement;
  logic           co_i;
  logic           sign_i;
  logic [W-1:0]   operand;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   mag_o;
  logic           co_o;
  logic           sign_o;
  logic           zero_o;
  logic [LZW-1:0] lzc_o;

  modport master (
    output flush, in_valid, complement, co_i, sign_i, operand, out_ready,
    input  in_ready, out_valid, mag_o, co_o, sign_o, zero_o, lzc_o
  );

  modport slave (
    input  flush, in_valid, complement, co_i, sign_i, operand, out_ready,
    output in_ready, out_valid, mag_o, co_o, sign_o, zero_o, lzc_o
  );
endinterface

// File: rtl/fp_postcomp_pipe.sv
// Post-complement stage of the FP adder: converts the raw significand sum to
// sign-magnitude, flips the sign on a negative subtraction, and produces a zero
// flag and leading-zero count for the normaliser. Results travel through a
// STAGES-deep valid/ready pipeline with full backpressure and synchronous flush.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (dominates flush and handshakes)
//   bus    fp_postcomp_pipe_if slave modport (handshakes, beat in, result out)
module fp_postcomp_pipe #(
  parameter int unsigned W      = 27,
  parameter int unsigned STAGES = 1,
  parameter int unsigned LZW    = $clog2(W + 1)
) (
  input logic               clk,
  input logic               reset,
  fp_postcomp_pipe_if.slave bus
);

  typedef struct packed {
    logic [W-1:0]   mag;
    logic           co;
    logic           sign;
    logic           zero;
    logic [LZW-1:0] lzc;
  } beat_t;

  beat_t              in_beat;
  logic [STAGES-1:0]  rdy;
  logic [STAGES-1:0]  v_q, v_d;
  beat_t              data_q [STAGES];
  beat_t              data_d [STAGES];

  // Correction, zero and lzc are purely combinational on the input beat.
  always_comb begin
    in_beat = '0;
    if (bus.complement && !bus.co_i) begin
      // Negative result of a subtraction: two's-complement back to magnitude.
      in_beat.mag  = ~bus.operand + W'(1);
      in_beat.sign = ~bus.sign_i;
    end else begin
      in_beat.mag  = bus.operand;
      in_beat.sign = bus.sign_i;
    end
    in_beat.co   = bus.complement ? 1'b0 : bus.co_i;
    in_beat.zero = (in_beat.mag == '0);
    // Exact cancellation yields +0; an addition keeps its sign even at zero.
    if (in_beat.zero && bus.complement) in_beat.sign = 1'b0;
    // Ascending scan: the highest set bit wins.
    in_beat.lzc = LZW'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (in_beat.mag[i]) in_beat.lzc = LZW'(int'(W) - 1 - i);
    end
  end

  // ready[k] = !v[k] || ready[k+1] unrolled: a stage can load if downstream
  // accepts or any stage from k to the output holds a bubble.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < int'(STAGES); j++) begin
        if (!v_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (rdy[0]) begin
      v_d[0] = bus.in_valid;
      if (bus.in_valid) data_d[0] = in_beat;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
    // Flush only kills the valids; stale data is harmless behind out_valid=0.
    if (bus.flush) v_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) data_q[k] <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.mag_o     = data_q[STAGES-1].mag;
  assign bus.co_o      = data_q[STAGES-1].co;
  assign bus.sign_o    = data_q[STAGES-1].sign;
  assign bus.zero_o    = data_q[STAGES-1].zero;
  assign bus.lzc_o     = data_q[STAGES-1].lzc;

endmodule

// File: tb/tb_fp_postcomp_pipe.sv
// Directed bench for fp_postcomp_pipe: three instances (STAGES=1,2,3) sharing
// clock and reset, each driven through its own interface.
module tb_fp_postcomp_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fp_postcomp_pipe_if #(.W(27)) if1 ();
  fp_postcomp_pipe_if #(.W(27)) if2 ();
  fp_postcomp_pipe_if #(.W(27)) if3 ();

  fp_postcomp_pipe #(.W(27), .STAGES(1)) u_s1 (.clk(clk), .reset(reset), .bus(if1));
  fp_postcomp_pipe #(.W(27), .STAGES(2)) u_s2 (.clk(clk), .reset(reset), .bus(if2));
  fp_postcomp_pipe #(.W(27), .STAGES(3)) u_s3 (.clk(clk), .reset(reset), .bus(if3));

  typedef struct packed {
    logic        c;
    logic        co;
    logic        s;
    logic [26:0] op;
    logic [26:0] mag;
    logic        eco;
    logic        esign;
    logic        ezero;
    logic [4:0]  elzc;
  } vec_t;

  vec_t vecs [8];

  // STAGES=2 backpressure timeline, indexed by cycle.
  logic [6:0] exp_ir  = 7'b1110011;
  logic [9:0] exp_ov  = 10'b0111111100;
  int exp_mag2 [10]   = '{0, 0, 1, 1, 1, 2, 3, 4, 5, 0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.flush = 0; if1.in_valid = 0; if1.complement = 0; if1.co_i = 0; if1.sign_i = 0;
    if1.operand = '0; if1.out_ready = 1;
    if2.flush = 0; if2.in_valid = 0; if2.complement = 0; if2.co_i = 0; if2.sign_i = 0;
    if2.operand = '0; if2.out_ready = 1;
    if3.flush = 0; if3.in_valid = 0; if3.complement = 0; if3.co_i = 0; if3.sign_i = 0;
    if3.operand = '0; if3.out_ready = 1;
  endtask

  task automatic check_zero3(input string tag);
    check_eq({tag, " out_valid"}, 32'(if3.out_valid), 0);
    check_eq({tag, " mag"},       32'(if3.mag_o),     0);
    check_eq({tag, " co"},        32'(if3.co_o),      0);
    check_eq({tag, " sign"},      32'(if3.sign_o),    0);
    check_eq({tag, " zero"},      32'(if3.zero_o),    0);
    check_eq({tag, " lzc"},       32'(if3.lzc_o),     0);
    check_eq({tag, " in_ready"},  32'(if3.in_ready),  1);
  endtask

  // Loads three beats into the STAGES=3 pipe with the output stalled.
  task automatic fill3();
    if3.out_ready  = 0;
    if3.complement = 0;
    if3.co_i       = 1;
    if3.sign_i     = 1;
    for (int i = 0; i < 3; i++) begin
      if3.in_valid = 1;
      if3.operand  = 27'(7 + i);
      tick();
    end
    if3.in_valid = 0;
    #1;
    check_eq("fill3 out_valid", 32'(if3.out_valid), 1);
    check_eq("fill3 mag",       32'(if3.mag_o),     7);
    check_eq("fill3 co",        32'(if3.co_o),      1);
    check_eq("fill3 in_ready",  32'(if3.in_ready),  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nxt;
    logic acc;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 27'h0000005, 27'h7FFFFFB, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 27'h0001000, 27'h0001000, 1'b0, 1'b1, 1'b0, 5'd14};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 27'h4000000, 27'h4000000, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 27'h0000000, 27'h0000000, 1'b0, 1'b0, 1'b1, 5'd27};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 27'h0000000, 27'h0000000, 1'b0, 1'b0, 1'b1, 5'd27};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 27'h0000000, 27'h0000000, 1'b0, 1'b1, 1'b1, 5'd27};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 27'h0000001, 27'h7FFFFFF, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 27'h7FFFFFF, 27'h0000001, 1'b0, 1'b1, 1'b0, 5'd26};

    idle_all();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    check_eq("rst out_valid", 32'(if1.out_valid), 0);
    check_eq("rst mag",       32'(if1.mag_o),     0);
    check_eq("rst sign",      32'(if1.sign_o),    0);
    check_eq("rst zero",      32'(if1.zero_o),    0);
    check_eq("rst lzc",       32'(if1.lzc_o),     0);
    check_eq("rst in_ready",  32'(if3.in_ready),  1);

    // STAGES=1 correction vectors, one per cycle.
    for (int i = 0; i < 8; i++) begin
      if1.in_valid   = 1;
      if1.complement = vecs[i].c;
      if1.co_i       = vecs[i].co;
      if1.sign_i     = vecs[i].s;
      if1.operand    = vecs[i].op;
      tick();
      check_eq($sformatf("v%0d out_valid", i), 32'(if1.out_valid), 1);
      check_eq($sformatf("v%0d mag", i),       32'(if1.mag_o),     32'(vecs[i].mag));
      check_eq($sformatf("v%0d co", i),        32'(if1.co_o),      32'(vecs[i].eco));
      check_eq($sformatf("v%0d sign", i),      32'(if1.sign_o),    32'(vecs[i].esign));
      check_eq($sformatf("v%0d zero", i),      32'(if1.zero_o),    32'(vecs[i].ezero));
      check_eq($sformatf("v%0d lzc", i),       32'(if1.lzc_o),     32'(vecs[i].elzc));
    end
    if1.in_valid = 0;
    tick();
    check_eq("s1 drain out_valid", 32'(if1.out_valid), 0);

    // Flush with an acceptable beat present: it must be discarded.
    if1.in_valid = 1;
    if1.flush    = 1;
    if1.operand  = 27'h55;
    tick();
    if1.in_valid = 0;
    if1.flush    = 0;
    check_eq("s1 flush out_valid", 32'(if1.out_valid), 0);

    // STAGES=2 backpressure: beats 1..5, output stalled for the first 4 cycles.
    nxt = 1;
    for (int c = 0; c < 10; c++) begin
      if2.in_valid  = (nxt <= 5);
      if2.operand   = 27'(nxt);
      if2.out_ready = (c >= 4);
      #1;
      if (c <= 6) check_eq($sformatf("bp c%0d in_ready", c), 32'(if2.in_ready), 32'(exp_ir[c]));
      check_eq($sformatf("bp c%0d out_valid", c), 32'(if2.out_valid), 32'(exp_ov[c]));
      if (exp_ov[c]) check_eq($sformatf("bp c%0d mag", c), 32'(if2.mag_o), 32'(exp_mag2[c]));
      acc = if2.in_valid && if2.in_ready;
      tick();
      if (acc) nxt++;
    end
    if2.in_valid = 0;

    // STAGES=3 continuous traffic: output is the input delayed by 3 cycles.
    if3.out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      if3.in_valid = (c < 8);
      if3.operand  = (c < 8) ? (27'(1) << (3 * c)) : 27'(0);
      #1;
      check_eq($sformatf("s3 c%0d in_ready", c), 32'(if3.in_ready), 1);
      check_eq($sformatf("s3 c%0d out_valid", c), 32'(if3.out_valid),
               32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) begin
        check_eq($sformatf("s3 c%0d mag", c), 32'(if3.mag_o), 32'(1) << (3 * (c - 3)));
        check_eq($sformatf("s3 c%0d lzc", c), 32'(if3.lzc_o), 32'(26 - 3 * (c - 3)));
      end
      tick();
    end
    if3.in_valid = 0;

    // Flush with three beats in flight.
    fill3();
    if3.flush    = 1;
    if3.in_valid = 1;
    if3.operand  = 27'h55;
    tick();
    if3.flush    = 0;
    if3.in_valid = 0;
    if3.out_ready = 1;
    #1;
    check_eq("flush out_valid", 32'(if3.out_valid), 0);
    check_eq("flush in_ready",  32'(if3.in_ready),  1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq($sformatf("flush c%0d quiet", c), 32'(if3.out_valid), 0);
    end

    // Reset with three beats in flight.
    fill3();
    reset = 1;
    tick();
    reset = 0;
    #1;
    check_zero3("reset");

    // Reset and flush together behave as reset.
    fill3();
    reset        = 1;
    if3.flush    = 1;
    if3.in_valid = 1;
    tick();
    reset        = 0;
    if3.flush    = 0;
    if3.in_valid = 0;
    if3.out_ready = 1;
    #1;
    check_zero3("rst+flush");

    // Pipe still works afterwards.
    if3.complement = 0;
    if3.co_i       = 0;
    if3.sign_i     = 0;
    if3.operand    = 27'h3;
    if3.in_valid   = 1;
    tick();
    if3.in_valid = 0;
    tick();
    check_eq("post early out_valid", 32'(if3.out_valid), 0);
    tick();
    check_eq("post out_valid", 32'(if3.out_valid), 1);
    check_eq("post mag",       32'(if3.mag_o),     3);
    check_eq("post lzc",       32'(if3.lzc_o),     25);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_postcomp_pipe.md
# fp_postcomp_pipe

Parametrised, pipelined post-complement stage for the floating-point adder datapath. It sits between the significand add/subtract and the normalisation shifter. For each result it:
- fixes the sign-magnitude of the raw sum according to the complement/carry rule;
- flips the result sign when the subtraction went negative;
- produces a zero flag and a leading-zero count for the normaliser.

Results move through a valid/ready pipeline of configurable depth with full backpressure and a synchronous flush.

## Interface
Parameters:
- W, 27, significand datapath width (operand and magnitude).
- STAGES, 1, pipeline register stages (legal 1..3); latency in cycles.
- LZW, $clog2(W+1), width of the leading-zero count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous flush; drops all in-flight entries.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- complement  input  1  upstream performed an effective subtraction.
- co_i  input  1  carry out of the upstream adder.
- sign_i  input  1  sign of the result before correction.
- operand  input  W  raw adder sum.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- mag_o  output  W  corrected magnitude.
- co_o  output  1  corrected carry.
- sign_o  output  1  corrected sign.
- zero_o  output  1  mag_o == 0.
- lzc_o  output  LZW  leading zeros in mag_o (W when zero).

## Operation
Correction rule, evaluated on the accepted input beat and all modulo 2^W:
- complement=1, co_i=1: mag = operand, co = 0, sign = sign_i.
- complement=1, co_i=0: mag = ~operand + 1, co = 0, sign = ~sign_i.
- complement=0: mag = operand, co = co_i, sign = sign_i.

Flags and zero handling:
- zero = (mag == 0).
- If zero and complement=1, sign is forced to 0 (round-to-nearest exact-cancellation rule). This covers complement=1, co_i=0, operand=0, where ~0+1 wraps to 0.
- If complement=0, sign is passed unchanged even when mag is 0.
- lzc = number of consecutive zero bits from bit W-1 downward; W if zero.

Pipeline structure:
- All correction, zero and lzc logic is combinational on the input and captured into stage 1.
- Stages 2..STAGES are pure delay registers. The outputs are driven directly from the last stage's registers.

Handshake:
- Each stage k has a valid bit v[k].
- A stage may load when ready[k] = !v[k] || ready[k+1], where ready[STAGES+1] = out_ready.
- in_ready = ready[1]; out_valid = v[STAGES].
- A beat transfers in on in_valid && in_ready and out on out_valid && out_ready.
- A stage that is stalled holds its data unchanged. out_valid and data stay stable until accepted.
- Order is strictly preserved. No beat is dropped or duplicated except by flush or reset.

## Timing
- Reset (reset=1 at an edge): all v[k] cleared and all data registers cleared. Outputs then read out_valid=0, mag_o=0, co_o=0, sign_o=0, zero_o=0, lzc_o=0.
- reset dominates flush and any handshake in the same cycle.
- flush: clears all v[k] at the edge. A beat presented with in_valid the same cycle is discarded. Data registers may keep stale values, but out_valid=0.
- Reset or flush mid-stream: in_ready=1 on the next cycle and the pipeline is empty.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, when downstream is not stalling.
- Throughput: one beat per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 combinationally.
- in_ready depends combinationally on out_ready only through the stage-valid chain. There is no path from in_valid to in_ready.
- Simultaneous output drain and input accept when full (out_ready=1): both occur in the same cycle and occupancy is unchanged.

## Test plan
- W=27, STAGES=1: complement=1, co_i=0, sign_i=0, operand=27'h0000005 -> after 1 cycle mag_o=27'h7FFFFFB, sign_o=1, co_o=0, zero_o=0, lzc_o=0.
- complement=1, co_i=1, sign_i=1, operand=27'h0001000 -> mag_o=27'h0001000, co_o=0, sign_o=1, lzc_o=14. Then complement=0, co_i=1, operand=27'h4000000 -> co_o=1, mag unchanged, lzc_o=0.
- Zero cancellation: complement=1, co_i=1, sign_i=1, operand=0 -> zero_o=1, sign_o=0, lzc_o=27. Also complement=1, co_i=0, operand=0 -> mag_o=0, sign_o=0. And complement=0, sign_i=1, operand=0 -> sign_o=1.
- STAGES=2 backpressure: stream 5 beats (operand=1..5) with out_ready=0 for the first 4 cycles -> in_ready drops after 2 beats are accepted. Release -> outputs 1..5 in order, no gaps once streaming, with out_valid/data stable while stalled.
- STAGES=3, continuous traffic with out_ready=1: output equals input delayed by 3 cycles, one beat per cycle.
- Mid-stream events:
  - Assert flush with 3 beats in flight -> out_valid=0 next cycle and the flushed beats never emerge.
  - Repeat with reset -> all outputs 0 next cycle.
  - reset and flush together -> reset behaviour.
